// File: rtl/mac_array_wlu_pp_pkg.sv
// Shared constants and address-field helpers for the MAC array weight load unit.
package acc_pkg;

   localparam int ARRAY_NUM = 32;
   localparam int PE_GRP    = 4;
   localparam int DATA_W    = 32;
   localparam int KTAPS     = 9;
   localparam int GRP_W     = 3;
   localparam int CNT_W     = 16;
   localparam int ADDR_W    = 32;

   // Weight address field positions.
   localparam int MODE_BIT  = 31;
   localparam int TAP_LSB   = 6;
   localparam int TAP_W     = 4;
   localparam int ICH_LSB   = 0;
   localparam int ICH_W     = 4;

   typedef struct packed {
      logic             mode_1x1;
      logic [TAP_W-1:0] tap;
      logic [ICH_W-1:0] in_ch;
   } wl_fields_t;

   // Splits a weight address into its mode, tap and input-channel fields.
   function automatic wl_fields_t decode_fields(input logic [ADDR_W-1:0] addr);
      wl_fields_t f;
      f.mode_1x1 = addr[MODE_BIT];
      f.tap      = addr[TAP_LSB +: TAP_W];
      f.in_ch    = addr[ICH_LSB +: ICH_W];
      return f;
   endfunction

endpackage

// File: rtl/mac_array_wlu_pp_if.sv
// Weight word channel from the BIU: valid/ready handshake with address, data and last flag.
interface mac_array_wlu_pp_if #(
   parameter int DATA_W = acc_pkg::DATA_W
);
   logic                      wl_valid;
   logic                      wl_ready;
   logic [acc_pkg::ADDR_W-1:0] wl_addr;
   logic [DATA_W-1:0]         wl_data;
   logic                      wl_last;

   modport master (output wl_valid, output wl_addr, output wl_data, output wl_last, input wl_ready);
   modport slave  (input wl_valid, input wl_addr, input wl_data, input wl_last, output wl_ready);
endinterface

// File: rtl/mac_array_wlu_pp_bank_ctrl.sv
// Ping-pong bank bookkeeping: fill/compute pointers, full flags and release error.
module wlu_bank_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       accept,
   input  logic       last,
   input  logic       cmp_release,
   output logic       fill_bank,
   output logic       cmp_bank,
   output logic [1:0] full,
   output logic       wl_ready,
   output logic       cmp_valid,
   output logic       err_rel
);

   logic       fill_bank_r, fill_bank_nxt_s;
   logic       cmp_bank_r,  cmp_bank_nxt_s;
   logic [1:0] full_r,      full_nxt_s;
   logic       err_rel_r,   err_rel_nxt_s;

   // Next-state for pointers and full flags; fill and release always hit different banks.
   always_comb begin
      full_nxt_s      = full_r;
      fill_bank_nxt_s = fill_bank_r;
      cmp_bank_nxt_s  = cmp_bank_r;
      err_rel_nxt_s   = err_rel_r;
      if (accept && last) begin
         full_nxt_s[fill_bank_r] = 1'b1;
         fill_bank_nxt_s         = ~fill_bank_r;
      end else begin
         fill_bank_nxt_s = fill_bank_r;
      end
      if (cmp_release && full_r[cmp_bank_r]) begin
         full_nxt_s[cmp_bank_r] = 1'b0;
         cmp_bank_nxt_s         = ~cmp_bank_r;
      end else if (cmp_release) begin
         err_rel_nxt_s = 1'b1;
      end else begin
         cmp_bank_nxt_s = cmp_bank_r;
      end
   end

   // Bank state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_r      <= 2'b00;
         fill_bank_r <= 1'b0;
         cmp_bank_r  <= 1'b0;
         err_rel_r   <= 1'b0;
      end else begin
         full_r      <= full_nxt_s;
         fill_bank_r <= fill_bank_nxt_s;
         cmp_bank_r  <= cmp_bank_nxt_s;
         err_rel_r   <= err_rel_nxt_s;
      end
   end

   assign fill_bank = fill_bank_r;
   assign cmp_bank  = cmp_bank_r;
   assign full      = full_r;
   assign wl_ready  = ~full_r[fill_bank_r];
   assign cmp_valid = full_r[cmp_bank_r];
   assign err_rel   = err_rel_r;

endmodule

// File: rtl/mac_array_wlu_pp.sv
// Ping-pong weight load unit: decodes BIU weight words into per-group lanes and per-PE tap enables.
module mac_array_wlu_pp
   import acc_pkg::*;
#(
   parameter int ARRAY_NUM = acc_pkg::ARRAY_NUM,
   parameter int PE_GRP    = acc_pkg::PE_GRP,
   parameter int DATA_W    = acc_pkg::DATA_W,
   parameter int KTAPS     = acc_pkg::KTAPS,
   parameter int GRP_W     = acc_pkg::GRP_W,
   parameter int CNT_W     = acc_pkg::CNT_W
) (
   input  logic                                  clk,
   input  logic                                  rst,
   mac_array_wlu_pp_if.slave                     wl,
   output logic [(ARRAY_NUM/PE_GRP)*DATA_W-1:0]  weight_load,
   output logic [ARRAY_NUM*(KTAPS+1)-1:0]        weight_load_en,
   output logic [1:0]                            weight_load_sel,
   output logic                                  cmp_bank,
   output logic                                  cmp_valid,
   input  logic                                  cmp_release,
   output logic [CNT_W-1:0]                      wl_cnt,
   output logic [1:0]                            err
);

   localparam int NGRP = ARRAY_NUM / PE_GRP;
   localparam int EN_W = KTAPS + 1;

   logic                       wl_ready_s;
   logic                       accept_s;
   logic                       fill_bank_s;
   logic [1:0]                 full_s;
   logic                       err_rel_s;
   wl_fields_t                 fld_s;
   logic [GRP_W-1:0]           grp_s;
   logic                       bad_tap_s;
   logic [EN_W-1:0]            base_s;
   logic [NGRP*DATA_W-1:0]     ld_nxt_s;
   logic [ARRAY_NUM*EN_W-1:0]  en_nxt_s;

   logic [NGRP*DATA_W-1:0]     ld_r;
   logic [ARRAY_NUM*EN_W-1:0]  en_r;
   logic [1:0]                 sel_r;
   logic [CNT_W-1:0]           cnt_r;
   logic                       err_tap_r;

   wlu_bank_ctrl u_bank_ctrl (
      .clk         (clk),
      .rst         (rst),
      .accept      (accept_s),
      .last        (wl.wl_last),
      .cmp_release (cmp_release),
      .fill_bank   (fill_bank_s),
      .cmp_bank    (cmp_bank),
      .full        (full_s),
      .wl_ready    (wl_ready_s),
      .cmp_valid   (cmp_valid),
      .err_rel     (err_rel_s)
   );

   assign wl.wl_ready = wl_ready_s;
   assign accept_s    = wl.wl_valid & wl_ready_s;

   // Address decode: tap enable base per mode, bad taps produce an all-zero base.
   always_comb begin
      fld_s     = decode_fields(wl.wl_addr);
      grp_s     = wl.wl_addr[GRP_W-1:0];
      bad_tap_s = ~fld_s.mode_1x1 && (fld_s.tap >= TAP_W'(KTAPS));
      base_s    = '0;
      if (fld_s.mode_1x1) begin
         base_s[KTAPS] = 1'b1;
      end else if (!bad_tap_s) begin
         base_s = EN_W'(1) << fld_s.tap;
      end else begin
         base_s = '0;
      end
   end

   // Fan the accepted word out to its group lane and the PEs of that group.
   always_comb begin
      ld_nxt_s = '0;
      en_nxt_s = '0;
      for (int l = 0; l < NGRP; l++) begin
         if (accept_s && !bad_tap_s && (grp_s == GRP_W'(l))) begin
            ld_nxt_s[l*DATA_W +: DATA_W] = wl.wl_data;
         end else begin
            ld_nxt_s[l*DATA_W +: DATA_W] = '0;
         end
      end
      for (int p = 0; p < ARRAY_NUM; p++) begin
         if (accept_s && (grp_s == GRP_W'(p / PE_GRP))) begin
            en_nxt_s[p*EN_W +: EN_W] = base_s;
         end else begin
            en_nxt_s[p*EN_W +: EN_W] = '0;
         end
      end
   end

   // Registered decode outputs, word counter and bad-tap sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         ld_r      <= '0;
         en_r      <= '0;
         sel_r     <= 2'b00;
         cnt_r     <= '0;
         err_tap_r <= 1'b0;
      end else begin
         ld_r <= ld_nxt_s;
         en_r <= en_nxt_s;
         if (accept_s) begin
            sel_r <= {fill_bank_s, fld_s.in_ch[3]};
            cnt_r <= wl.wl_last ? '0 : cnt_r + CNT_W'(1);
            if (bad_tap_s) begin
               err_tap_r <= 1'b1;
            end
         end
      end
   end

   assign weight_load     = ld_r;
   assign weight_load_en  = en_r;
   assign weight_load_sel = sel_r;
   assign wl_cnt          = cnt_r;
   assign err             = {err_rel_s, err_tap_r};

endmodule
